// File: rtl/ps2_codes_pkg.sv
// Shared PS/2 set-2 constants, decoder state encoding and event-entry layout.
package ps2_codes_pkg;

    // Prefix and keyboard status bytes
    localparam logic [7:0] PS2_EXT     = 8'hE0;
    localparam logic [7:0] PS2_BRK     = 8'hF0;
    localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
    localparam logic [7:0] PS2_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RESEND  = 8'hFE;
    localparam logic [7:0] PS2_ECHO    = 8'hEE;
    localparam logic [7:0] PS2_ERR0    = 8'h00;
    localparam logic [7:0] PS2_ERR1    = 8'hFF;

    // Decoder states: which prefixes have been seen for the event in progress
    typedef enum logic [1:0] {
        DEC_IDLE    = 2'd0,
        DEC_EXT     = 2'd1,
        DEC_BRK     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } dec_state_e;

    // Event entry {code, ext, brk, repeat}
    localparam int unsigned EV_REPEAT_BIT = 0;
    localparam int unsigned EV_BRK_BIT    = 1;
    localparam int unsigned EV_EXT_BIT    = 2;
    localparam int unsigned EV_CODE_LSB   = 3;
    localparam int unsigned EV_CODE_W     = 8;
    localparam int unsigned EV_WIDTH      = 11;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rpt;
    } ps2_event_t;

    // Bytes the keyboard sends that are not keystrokes
    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK)  || (b == PS2_RESEND) ||
               (b == PS2_ECHO)   || (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous first-word-fall-through FIFO with sticky overflow flag.
//   CLOCK_50/reset : clock, synchronous active-high reset
//   wr_en/wr_data  : push; dropped (and overflow set) when full without a pop
//   rd_en/rd_data  : pop head / head word, valid whenever empty=0
//   full/empty     : occupancy flags
//   overflow       : sticky drop flag, cleared by overflow_clr (new drop wins)
module ps2_event_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             overflow_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_pop_c;
    logic             do_push_c;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign rd_data  = mem[rd_ptr];

    // A pop frees the slot the simultaneous push will use, so full+pop+push is legal
    assign do_pop_c  = rd_en && !empty;
    assign do_push_c = wr_en && (!full || do_pop_c);

    // Storage needs no reset; only pointers and count define contents
    always_ff @(posedge CLOCK_50) begin
        if (do_push_c) mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push_c) - CW'(do_pop_c);
            if (wr_en && !do_push_c) overflow <= 1'b1;
            else if (overflow_clr)   overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 byte stream to make/break events, per-key held state and event FIFO.
//   CLOCK_50/reset                    : clock, synchronous active-high reset
//   ps2_key_data/ps2_key_pressed      : received byte and its one-cycle strobe
//   key_held/key_down_pulse/key_up_pulse : per tracked key state and edges
//   event_valid/code/ext/break/repeat : FIFO head, event_rd pops it
//   last_code                         : code of the latest completed event
//   fifo_overflow/overflow_clr        : sticky dropped-event flag and its clear
module ps2_key_tracker
    import ps2_codes_pkg::*;
#(
    parameter int unsigned              NUM_KEYS   = 4,
    parameter logic [NUM_KEYS*9-1:0]    KEY_CODES  = {9'h1_75, 9'h0_1D, 9'h0_29, 9'h0_76},
    parameter int unsigned              FIFO_DEPTH = 8
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [7:0]          ps2_key_data,
    input  logic                ps2_key_pressed,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_down_pulse,
    output logic [NUM_KEYS-1:0] key_up_pulse,
    output logic                event_valid,
    output logic [7:0]          event_code,
    output logic                event_ext,
    output logic                event_break,
    output logic                event_repeat,
    input  logic                event_rd,
    output logic [7:0]          last_code,
    output logic                fifo_overflow,
    input  logic                overflow_clr
);

    dec_state_e            state;
    dec_state_e            next_state;
    logic                  done_c;
    logic                  done_ext_c;
    logic                  done_brk_c;
    logic [NUM_KEYS-1:0]   match_c;
    logic                  repeat_c;
    ps2_event_t            push_ev_c;
    logic [EV_WIDTH-1:0]   fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Decoder state register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= DEC_IDLE;
        else       state <= next_state;
    end

    // Prefix decoding; done_c marks the byte that completes an event
    always_comb begin
        next_state = state;
        done_c     = 1'b0;
        done_ext_c = 1'b0;
        done_brk_c = 1'b0;
        if (ps2_key_pressed) begin
            case (state)
                DEC_IDLE: begin
                    if (ps2_key_data == PS2_EXT)          next_state = DEC_EXT;
                    else if (ps2_key_data == PS2_BRK)     next_state = DEC_BRK;
                    else if (!is_status_byte(ps2_key_data)) done_c = 1'b1;
                end
                DEC_EXT: begin
                    if (ps2_key_data == PS2_BRK) begin
                        next_state = DEC_EXT_BRK;
                    end else if (ps2_key_data != PS2_EXT) begin
                        next_state = DEC_IDLE;
                        done_c     = 1'b1;
                        done_ext_c = 1'b1;
                    end
                end
                DEC_BRK: begin
                    // A second prefix after F0 is a protocol error: drop silently
                    next_state = DEC_IDLE;
                    if (ps2_key_data != PS2_EXT && ps2_key_data != PS2_BRK) begin
                        done_c     = 1'b1;
                        done_brk_c = 1'b1;
                    end
                end
                DEC_EXT_BRK: begin
                    next_state = DEC_IDLE;
                    if (ps2_key_data != PS2_EXT && ps2_key_data != PS2_BRK) begin
                        done_c     = 1'b1;
                        done_ext_c = 1'b1;
                        done_brk_c = 1'b1;
                    end
                end
                default: next_state = DEC_IDLE;
            endcase
        end
    end

    // Tracked-key match and repeat detection for the completing event
    always_comb begin
        match_c = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            match_c[i] = done_c && (KEY_CODES[9*i +: 9] == {done_ext_c, ps2_key_data});
        end
        repeat_c       = !done_brk_c && (|(match_c & key_held));
        push_ev_c.code = ps2_key_data;
        push_ev_c.ext  = done_ext_c;
        push_ev_c.brk  = done_brk_c;
        push_ev_c.rpt  = repeat_c;
    end

    // Held bits, edge pulses and last completed code
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_held       <= '0;
            key_down_pulse <= '0;
            key_up_pulse   <= '0;
            last_code      <= '0;
        end else begin
            key_down_pulse <= '0;
            key_up_pulse   <= '0;
            if (done_c) last_code <= ps2_key_data;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if (match_c[i]) begin
                    if (done_brk_c) begin
                        key_held[i]     <= 1'b0;
                        key_up_pulse[i] <= key_held[i];
                    end else if (!key_held[i]) begin
                        key_held[i]       <= 1'b1;
                        key_down_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

    ps2_event_fifo #(
        .WIDTH (EV_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .wr_en        (done_c),
        .wr_data      (push_ev_c),
        .rd_en        (event_rd),
        .rd_data      (fifo_dout),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .overflow     (fifo_overflow),
        .overflow_clr (overflow_clr)
    );

    // Head fields read as zero while the FIFO is empty
    assign event_valid  = !fifo_empty;
    assign event_code   = fifo_empty ? 8'h00 : fifo_dout[EV_CODE_LSB +: EV_CODE_W];
    assign event_ext    = !fifo_empty && fifo_dout[EV_EXT_BIT];
    assign event_break  = !fifo_empty && fifo_dout[EV_BRK_BIT];
    assign event_repeat = !fifo_empty && fifo_dout[EV_REPEAT_BIT];

    a_fifo_flags: assert property (@(posedge CLOCK_50) disable iff (reset) !(fifo_full && fifo_empty));

endmodule
